// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Brief    : RV64 pipeline control. Owns the fetch PC, turns EX jump/hold
//            requests into IF/ID + ID/EX flush/stall, halts on misaligned
//            jump targets. Optional perf counters via PIPE_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter logic [63:0] RESET_PC     = 64'h8000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [63:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic [63:0] pc_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        halt_o,
`ifdef PIPE_CTRL_PERF_EN
  output logic [63:0] cycle_cnt_o,
  output logic [63:0] redirect_cnt_o,
  output logic [63:0] stall_cnt_o,
`endif
  output logic [63:0] bad_addr_o
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] bad_q, bad_d;
  logic        flush, stall;
  logic        aligned;
  logic        redirect;

  assign aligned = (jump_addr_i[1:0] == 2'b00);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    bad_d    = bad_q;
    flush    = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (jump_en_i && !aligned) begin
          flush   = 1'b1;
          bad_d   = jump_addr_i;
          state_d = ST_HALT;
        end else if (jump_en_i) begin
          // Jump beats a simultaneous hold: the holding instruction retires.
          flush    = 1'b1;
          redirect = 1'b1;
          pc_d     = jump_addr_i;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_INIT;
          end
        end else if (hold_flag_i) begin
          stall = 1'b1;
        end else begin
          pc_d = pc_q + 64'd4;
        end
      end
      ST_FLUSH: begin
        // Requests are ignored while NOPs are still draining through ID/EX.
        flush = 1'b1;
        pc_d  = pc_q + 64'd4;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        flush = 1'b1;
        stall = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
      pc_q    <= RESET_PC;
      bad_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      bad_q   <= bad_d;
    end
  end

  assign pc_o       = pc_q;
  assign bad_addr_o = bad_q;
  assign flush_o    = flush;
  assign stall_o    = stall;
  assign halt_o     = (state_q == ST_HALT);

`ifdef PIPE_CTRL_PERF_EN
  logic [63:0] cycle_cnt_q, redirect_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q    <= 64'd0;
      redirect_cnt_q <= 64'd0;
      stall_cnt_q    <= 64'd0;
    end else begin
      if (!halt_o) begin
        cycle_cnt_q <= cycle_cnt_q + 64'd1;
      end
      if (redirect) begin
        redirect_cnt_q <= redirect_cnt_q + 64'd1;
      end
      if (stall && !halt_o) begin
        stall_cnt_q <= stall_cnt_q + 64'd1;
      end
    end
  end

  assign cycle_cnt_o    = cycle_cnt_q;
  assign redirect_cnt_o = redirect_cnt_q;
  assign stall_cnt_o    = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Brief    : Directed self-checking bench for pipe_ctrl; dut1 uses
//            FLUSH_CYCLES=1, dut3 uses FLUSH_CYCLES=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        j1 = 1'b0, h1 = 1'b0, j3 = 1'b0, h3 = 1'b0;
  logic [63:0] a1 = 64'd0, a3 = 64'd0;
  logic [63:0] pc1, pc3, bad1, bad3;
  logic        fl1, st1, ht1, fl3, st3, ht3;
  int          nvec = 0;
  int          nerr = 0;
`ifdef PIPE_CTRL_PERF_EN
  logic [63:0] cyc1, red1, stc1, cyc3, red3, stc3;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.RESET_PC(64'h8000_0000), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .jump_en_i(j1), .jump_addr_i(a1), .hold_flag_i(h1),
    .pc_o(pc1), .flush_o(fl1), .stall_o(st1), .halt_o(ht1),
`ifdef PIPE_CTRL_PERF_EN
    .cycle_cnt_o(cyc1), .redirect_cnt_o(red1), .stall_cnt_o(stc1),
`endif
    .bad_addr_o(bad1)
  );

  pipe_ctrl #(.RESET_PC(64'h8000_0000), .FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .jump_en_i(j3), .jump_addr_i(a3), .hold_flag_i(h3),
    .pc_o(pc3), .flush_o(fl3), .stall_o(st3), .halt_o(ht3),
`ifdef PIPE_CTRL_PERF_EN
    .cycle_cnt_o(cyc3), .redirect_cnt_o(red3), .stall_cnt_o(stc3),
`endif
    .bad_addr_o(bad3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    nvec++; if (pc1 !== 64'h8000_0000) begin nerr++; $display("FAIL rst_pc1 got %h exp %h", pc1, 64'h8000_0000); end
    nvec++; if (pc3 !== 64'h8000_0000) begin nerr++; $display("FAIL rst_pc3 got %h exp %h", pc3, 64'h8000_0000); end
    nvec++; if ({fl1, st1, ht1} !== 3'b000) begin nerr++; $display("FAIL rst_ctl got %b exp 000", {fl1, st1, ht1}); end
    nvec++; if (bad1 !== 64'd0) begin nerr++; $display("FAIL rst_bad got %h exp 0", bad1); end
    rst = 1'b1;
    #1;
    nvec++; if (pc1 !== 64'h8000_0000) begin nerr++; $display("FAIL rel_pc0 got %h exp %h", pc1, 64'h8000_0000); end
    tick();
    nvec++; if (pc1 !== 64'h8000_0004) begin nerr++; $display("FAIL rel_pc1 got %h exp %h", pc1, 64'h8000_0004); end
    tick();
    nvec++; if (pc1 !== 64'h8000_0008) begin nerr++; $display("FAIL rel_pc2 got %h exp %h", pc1, 64'h8000_0008); end
    tick();
    nvec++; if (pc1 !== 64'h8000_000C) begin nerr++; $display("FAIL rel_pc3 got %h exp %h", pc1, 64'h8000_000C); end
    nvec++; if (pc3 !== 64'h8000_000C) begin nerr++; $display("FAIL rel_pc3b got %h exp %h", pc3, 64'h8000_000C); end
    nvec++; if ({fl1, st1} !== 2'b00) begin nerr++; $display("FAIL rel_ctl got %b exp 00", {fl1, st1}); end
  endtask

  task automatic test_jump();
    j1 = 1'b1; a1 = 64'h8000_0100;
    #1;
    nvec++; if ({fl1, st1} !== 2'b10) begin nerr++; $display("FAIL jmp_ctl got %b exp 10", {fl1, st1}); end
    tick();
    j1 = 1'b0;
    #1;
    nvec++; if (pc1 !== 64'h8000_0100) begin nerr++; $display("FAIL jmp_pc got %h exp %h", pc1, 64'h8000_0100); end
    nvec++; if (fl1 !== 1'b0) begin nerr++; $display("FAIL jmp_fl_end got %b exp 0", fl1); end
    tick();
    nvec++; if (pc1 !== 64'h8000_0104) begin nerr++; $display("FAIL jmp_pc2 got %h exp %h", pc1, 64'h8000_0104); end
  endtask

  task automatic test_hold();
    j1 = 1'b1; a1 = 64'h8000_0010;
    tick();
    j1 = 1'b0; h1 = 1'b1;
    #1;
    nvec++; if ({fl1, st1} !== 2'b01) begin nerr++; $display("FAIL hold_ctl got %b exp 01", {fl1, st1}); end
    nvec++; if (pc1 !== 64'h8000_0010) begin nerr++; $display("FAIL hold_pc0 got %h exp %h", pc1, 64'h8000_0010); end
    tick();
    nvec++; if (st1 !== 1'b1) begin nerr++; $display("FAIL hold_st2 got %b exp 1", st1); end
    nvec++; if (pc1 !== 64'h8000_0010) begin nerr++; $display("FAIL hold_pc1 got %h exp %h", pc1, 64'h8000_0010); end
    tick();
    h1 = 1'b0;
    #1;
    nvec++; if (pc1 !== 64'h8000_0010) begin nerr++; $display("FAIL hold_pc2 got %h exp %h", pc1, 64'h8000_0010); end
    nvec++; if (st1 !== 1'b0) begin nerr++; $display("FAIL hold_st_end got %b exp 0", st1); end
`ifdef PIPE_CTRL_PERF_EN
    nvec++; if (stc1 !== 64'd2) begin nerr++; $display("FAIL stall_cnt got %0d exp 2", stc1); end
`endif
    tick();
    nvec++; if (pc1 !== 64'h8000_0014) begin nerr++; $display("FAIL hold_pc3 got %h exp %h", pc1, 64'h8000_0014); end
  endtask

  task automatic test_jump_hold();
    j1 = 1'b1; h1 = 1'b1; a1 = 64'h8000_0040;
    #1;
    nvec++; if ({fl1, st1} !== 2'b10) begin nerr++; $display("FAIL jh_ctl got %b exp 10", {fl1, st1}); end
    tick();
    j1 = 1'b0; h1 = 1'b0;
    #1;
    nvec++; if (pc1 !== 64'h8000_0040) begin nerr++; $display("FAIL jh_pc got %h exp %h", pc1, 64'h8000_0040); end
  endtask

  task automatic test_misaligned();
    j1 = 1'b1; a1 = 64'h8000_0102;
    #1;
    nvec++; if ({fl1, st1, ht1} !== 3'b100) begin nerr++; $display("FAIL mis_ctl0 got %b exp 100", {fl1, st1, ht1}); end
    tick();
    j1 = 1'b1; a1 = 64'h8000_0200; h1 = 1'b1;
    #1;
    nvec++; if ({fl1, st1, ht1} !== 3'b111) begin nerr++; $display("FAIL mis_ctl1 got %b exp 111", {fl1, st1, ht1}); end
    nvec++; if (bad1 !== 64'h8000_0102) begin nerr++; $display("FAIL mis_bad got %h exp %h", bad1, 64'h8000_0102); end
    nvec++; if (pc1 !== 64'h8000_0040) begin nerr++; $display("FAIL mis_pc got %h exp %h", pc1, 64'h8000_0040); end
    tick();
    j1 = 1'b0; h1 = 1'b0;
    #1;
    nvec++; if (pc1 !== 64'h8000_0040) begin nerr++; $display("FAIL mis_frz got %h exp %h", pc1, 64'h8000_0040); end
    nvec++; if (ht1 !== 1'b1) begin nerr++; $display("FAIL mis_sticky got %b exp 1", ht1); end
  endtask

  task automatic test_flush3();
    j3 = 1'b1; a3 = 64'h8000_0200;
    #1;
    nvec++; if ({fl3, st3} !== 2'b10) begin nerr++; $display("FAIL f3_ctl0 got %b exp 10", {fl3, st3}); end
    tick();
    j3 = 1'b1; a3 = 64'h8000_0300; h3 = 1'b1;
    #1;
    nvec++; if ({fl3, st3} !== 2'b10) begin nerr++; $display("FAIL f3_ctl1 got %b exp 10", {fl3, st3}); end
    nvec++; if (pc3 !== 64'h8000_0200) begin nerr++; $display("FAIL f3_pc0 got %h exp %h", pc3, 64'h8000_0200); end
    tick();
    j3 = 1'b0; h3 = 1'b0;
    #1;
    nvec++; if (fl3 !== 1'b1) begin nerr++; $display("FAIL f3_fl2 got %b exp 1", fl3); end
    nvec++; if (pc3 !== 64'h8000_0204) begin nerr++; $display("FAIL f3_pc1 got %h exp %h", pc3, 64'h8000_0204); end
    tick();
    nvec++; if (fl3 !== 1'b0) begin nerr++; $display("FAIL f3_fl_end got %b exp 0", fl3); end
    nvec++; if (pc3 !== 64'h8000_0208) begin nerr++; $display("FAIL f3_pc2 got %h exp %h", pc3, 64'h8000_0208); end
    tick();
    nvec++; if (pc3 !== 64'h8000_020C) begin nerr++; $display("FAIL f3_pc3 got %h exp %h", pc3, 64'h8000_020C); end
  endtask

  task automatic test_async_reset();
    j3 = 1'b1; a3 = 64'h8000_0400;
    tick();
    j3 = 1'b0;
    #1;
    nvec++; if (fl3 !== 1'b1) begin nerr++; $display("FAIL ar_inflush got %b exp 1", fl3); end
    #1;
    rst = 1'b0;
    #1;
    nvec++; if (pc1 !== 64'h8000_0000) begin nerr++; $display("FAIL ar_pc1 got %h exp %h", pc1, 64'h8000_0000); end
    nvec++; if (pc3 !== 64'h8000_0000) begin nerr++; $display("FAIL ar_pc3 got %h exp %h", pc3, 64'h8000_0000); end
    nvec++; if ({fl1, st1, ht1} !== 3'b000) begin nerr++; $display("FAIL ar_ctl1 got %b exp 000", {fl1, st1, ht1}); end
    nvec++; if (bad1 !== 64'd0) begin nerr++; $display("FAIL ar_bad got %h exp 0", bad1); end
    nvec++; if (fl3 !== 1'b0) begin nerr++; $display("FAIL ar_fl3 got %b exp 0", fl3); end
    tick();
    rst = 1'b1;
    #1;
    nvec++; if (pc3 !== 64'h8000_0000) begin nerr++; $display("FAIL ar_rel got %h exp %h", pc3, 64'h8000_0000); end
    tick();
    nvec++; if (pc1 !== 64'h8000_0004) begin nerr++; $display("FAIL ar_pc1n got %h exp %h", pc1, 64'h8000_0004); end
    nvec++; if (pc3 !== 64'h8000_0004) begin nerr++; $display("FAIL ar_pc3n got %h exp %h", pc3, 64'h8000_0004); end
    nvec++; if (fl3 !== 1'b0) begin nerr++; $display("FAIL ar_fl3n got %b exp 0", fl3); end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_hold();
    test_jump_hold();
    test_misaligned();
    test_flush3();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
